// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// A registered borrow replaces the combinational ripple chain; start/done handshake.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh;
   logic [CNT_W-1:0] cnt;
   logic             borrow;
   logic             x, y, res_bit, borrow_nxt, last_bit;
   logic [WIDTH-1:0] res_nxt;

   function automatic logic fs_diff(input logic xi, input logic yi, input logic wi);
      return xi ^ yi ^ wi;
   endfunction

   function automatic logic fs_borrow(input logic xi, input logic yi, input logic wi);
      return (~xi & yi) | (~(xi ^ yi) & wi);
   endfunction

   always_comb begin
      x          = a_sh[0];
      y          = b_sh[0];
      res_bit    = fs_diff(x, y, borrow);
      borrow_nxt = fs_borrow(x, y, borrow);
      res_nxt    = {res_bit, res_sh[WIDTH-1:1]};
      last_bit   = (cnt == CNT_W'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SUB;
            end
         end
         SUB: begin
            busy = 1'b1;
            if (last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Shift datapath; diff/b_out are only written on the final bit so partial results stay hidden.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         cnt    <= '0;
         borrow <= 1'b0;
         diff   <= '0;
         b_out  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  res_sh <= '0;
                  cnt    <= '0;
                  borrow <= 1'b0;
               end
            end
            SUB: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= res_nxt;
               borrow <= borrow_nxt;
               cnt    <= cnt + CNT_W'(1);
               if (last_bit) begin
                  diff  <= res_nxt;
                  b_out <= borrow_nxt;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
